// File: rtl/lsu_split.sv
// Load/store unit with a valid/ready request port and a word-addressed dmem bus.
// Misaligned halfword/word accesses run as two aligned beats with lane merge/split.
module lsu_split #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned MEM_ADDR_BITS = 14,
  parameter bit          SPLIT_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  dmem_valid_o,
  input  logic                  dmem_ready_i,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [31:0]           dmem_wdata_o,
  output logic [3:0]            dmem_we_o,
  input  logic [31:0]           dmem_rdata_i
);

  localparam logic [1:0] DATA_BYTE      = 2'b00;
  localparam logic [1:0] DATA_HALF_WORD = 2'b01;
  localparam logic [1:0] DATA_WORD      = 2'b10;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, sign_q, split_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            mask_q;
  logic [63:0]           sdata_q;
  logic [63:0]           lbuf_q, lbuf_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;

  logic [2:0]            req_size_c;
  logic [7:0]            req_base_mask_c;
  logic [31:0]           req_wmask_c;
  logic                  req_illegal_c;
  logic [1:0]            req_off_c;
  logic                  req_split_c;
  logic [ADDR_WIDTH:0]   req_first_c, req_last_c;
  logic                  req_oob_c, req_err_c, accept_c;
  logic [7:0]            req_mask_c;
  logic [63:0]           req_sdata_c;
  logic [ADDR_WIDTH-1:0] base_addr_c;

  // Size, lane mask and store-data mask per access type
  always_comb begin
    req_illegal_c   = 1'b0;
    req_size_c      = 3'd4;
    req_base_mask_c = 8'h0F;
    req_wmask_c     = 32'hFFFF_FFFF;
    case (req_type_i)
      DATA_BYTE: begin
        req_size_c      = 3'd1;
        req_base_mask_c = 8'h01;
        req_wmask_c     = 32'h0000_00FF;
      end
      DATA_HALF_WORD: begin
        req_size_c      = 3'd2;
        req_base_mask_c = 8'h03;
        req_wmask_c     = 32'h0000_FFFF;
      end
      DATA_WORD: begin
        req_size_c      = 3'd4;
        req_base_mask_c = 8'h0F;
        req_wmask_c     = 32'hFFFF_FFFF;
      end
      default: req_illegal_c = 1'b1;
    endcase
  end

  assign req_off_c   = req_addr_i[1:0];
  assign req_split_c = (3'({1'b0, req_off_c}) + req_size_c) > 3'd4;
  assign req_first_c = {1'b0, req_addr_i};
  // Extra top bit keeps the last-byte address from wrapping past the end of the space
  assign req_last_c  = req_first_c + (ADDR_WIDTH+1)'(req_size_c) - (ADDR_WIDTH+1)'(1);
  assign req_oob_c   = ((req_first_c >> MEM_ADDR_BITS) != '0) ||
                       ((req_last_c  >> MEM_ADDR_BITS) != '0);
  assign req_err_c   = req_illegal_c || req_oob_c || (req_split_c && !SPLIT_EN);
  assign req_mask_c  = req_base_mask_c << req_off_c;
  assign req_sdata_c = {32'h0, req_wdata_i & req_wmask_c} << {req_off_c, 3'b000};
  assign accept_c    = req_valid_i && (state_q == IDLE);

  function automatic logic [31:0] load_fmt(input logic [63:0] b, input logic [1:0] off,
                                           input logic [2:0] size, input logic sx);
    logic [63:0] r;
    r = b >> {off, 3'b000};
    case (size)
      3'd1:    load_fmt = sx ? {{24{r[7]}}, r[7:0]}   : {24'h0, r[7:0]};
      3'd2:    load_fmt = sx ? {{16{r[15]}}, r[15:0]} : {16'h0, r[15:0]};
      default: load_fmt = r[31:0];
    endcase
  endfunction

  // Next state, load-buffer capture and response formation
  always_comb begin
    state_d      = state_q;
    lbuf_d       = lbuf_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (dmem_ready_i) begin
          lbuf_d[31:0] = dmem_rdata_i;
          if (split_q) begin
            state_d = BEAT1;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = we_q ? '0 : load_fmt(lbuf_d, addr_q[1:0], size_q, sign_q);
          end
        end
      end
      BEAT1: begin
        if (dmem_ready_i) begin
          lbuf_d[63:32] = dmem_rdata_i;
          state_d       = RESP;
          resp_valid_d  = 1'b1;
          resp_rdata_d  = we_q ? '0 : load_fmt(lbuf_d, addr_q[1:0], size_q, sign_q);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lbuf_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      lbuf_q       <= lbuf_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Request capture; held for the whole access so the bus stays stable under stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      split_q <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      sdata_q <= '0;
    end else if (accept_c) begin
      we_q    <= req_we_i;
      sign_q  <= req_sign_ext_i;
      split_q <= req_split_c;
      size_q  <= req_size_c;
      addr_q  <= req_addr_i;
      mask_q  <= req_mask_c;
      sdata_q <= req_sdata_c;
    end
  end

  assign base_addr_c  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign req_ready_o  = (state_q == IDLE);
  assign dmem_valid_o = (state_q == BEAT0) || (state_q == BEAT1);
  assign dmem_addr_o  = (state_q == BEAT0) ? base_addr_c :
                        (state_q == BEAT1) ? base_addr_c + ADDR_WIDTH'(4) : '0;
  assign dmem_we_o    = (state_q == BEAT0) ? (mask_q[3:0] & {4{we_q}}) :
                        (state_q == BEAT1) ? (mask_q[7:4] & {4{we_q}}) : 4'h0;
  assign dmem_wdata_o = !we_q              ? 32'h0 :
                        (state_q == BEAT0) ? sdata_q[31:0] :
                        (state_q == BEAT1) ? sdata_q[63:32] : 32'h0;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_lsu_split.sv
// Self-checking bench for lsu_split: memory model, beat and response scoreboards.
module tb_lsu_split;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i, req_we_i, req_sign_ext_i;
  logic [1:0]    req_type_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          req_ready_o, resp_valid_o, resp_err_o;
  logic [31:0]   resp_rdata_o;
  logic          dmem_valid_o, dmem_ready_i;
  logic [AW-1:0] dmem_addr_o;
  logic [31:0]   dmem_wdata_o, dmem_rdata_i;
  logic [3:0]    dmem_we_o;

  logic          ns_req_ready_o, ns_resp_valid_o, ns_resp_err_o, ns_dmem_valid_o;
  logic [31:0]   ns_resp_rdata_o, ns_dmem_wdata_o;
  logic [AW-1:0] ns_dmem_addr_o;
  logic [3:0]    ns_dmem_we_o;

  lsu_split #(.ADDR_WIDTH(AW), .MEM_ADDR_BITS(14), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o),
    .resp_rdata_o(resp_rdata_o), .dmem_valid_o(dmem_valid_o), .dmem_ready_i(dmem_ready_i),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_we_o(dmem_we_o),
    .dmem_rdata_i(dmem_rdata_i)
  );

  lsu_split #(.ADDR_WIDTH(AW), .MEM_ADDR_BITS(14), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(ns_req_ready_o), .req_we_i(req_we_i),
    .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(ns_resp_valid_o), .resp_err_o(ns_resp_err_o),
    .resp_rdata_o(ns_resp_rdata_o), .dmem_valid_o(ns_dmem_valid_o), .dmem_ready_i(dmem_ready_i),
    .dmem_addr_o(ns_dmem_addr_o), .dmem_wdata_o(ns_dmem_wdata_o), .dmem_we_o(ns_dmem_we_o),
    .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic [31:0]   wdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [31:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;
  int          stall_n = 0;
  int          wcnt = 0;
  bit          pend = 0;
  beat_t       prev;
  int          dv_cnt, ns_dv_cnt, ns_rv_cyc;
  logic        ns_rv_err;

  function automatic int size_of(input logic [1:0] ty);
    return (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
  endfunction

  // Byte-by-byte reference load from the bench memory
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] ty, input logic sx);
    int          sz;
    logic [31:0] r, ba, w;
    sz = size_of(ty);
    r  = 32'h0;
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      w  = mem[ba[13:2]];
      r[8*i +: 8] = w[8*ba[1:0] +: 8];
    end
    if (sx && sz < 4 && r[8*sz-1]) r = r | ~((32'h1 << (8*sz)) - 32'h1);
    return r;
  endfunction

  // Expected beats built per byte: which word it lands in and at which lane
  function automatic int push_beats(input logic we, input logic [31:0] a, input logic [1:0] ty,
                                    input logic [31:0] wd);
    beat_t       b [2];
    int          sz, nb, k;
    logic [31:0] ba;
    sz = size_of(ty);
    nb = 1;
    b[0].addr = {a[31:2], 2'b00};
    b[1].addr = {a[31:2], 2'b00} + 32'd4;
    for (int j = 0; j < 2; j++) begin
      b[j].we    = 4'h0;
      b[j].wdata = 32'h0;
    end
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      k  = (ba[31:2] != a[31:2]) ? 1 : 0;
      if (k == 1) nb = 2;
      if (we) begin
        b[k].we[ba[1:0]] = 1'b1;
        b[k].wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
    end
    for (int j = 0; j < nb; j++) beat_q.push_back(b[j]);
    return nb;
  endfunction

  task automatic txn(input logic we, input logic [1:0] ty, input logic sx, input logic [31:0] a,
                     input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                     input int stall, output int t_acc, output int t_resp);
    int    nb;
    bit    got;
    resp_t e, o;
    beat_t eb;
    for (int k = 0; k < 20 && !req_ready_o; k++) @(negedge clk);
    checks++;
    if (!req_ready_o) begin errors++; $display("FAIL ready_wait: req_ready_o stayed 0"); end
    stall_n = stall; wcnt = 0; pend = 0; dv_cnt = 0; ns_dv_cnt = 0; ns_rv_cyc = -1;
    req_valid_i = 1'b1; req_we_i = we; req_type_i = ty; req_sign_ext_i = sx;
    req_addr_i = a; req_wdata_i = wd;
    t_acc = cyc;
    nb = exp_err ? 0 : push_beats(we, a, ty, wd);
    e.err = exp_err; e.rdata = exp_rd;
    e.cyc = exp_err ? t_acc + 1 : t_acc + 1 + nb * (stall + 1);
    resp_q.push_back(e);
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_we_i = 1'($urandom); req_type_i = 2'($urandom);
    req_addr_i = $urandom; req_wdata_i = $urandom; req_sign_ext_i = 1'($urandom);
    got = 0; t_resp = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (ns_resp_valid_o) begin ns_rv_cyc = cyc; ns_rv_err = ns_resp_err_o; end
      if (ns_dmem_valid_o) ns_dv_cnt++;
      dmem_rdata_i = $urandom;
      if (dmem_valid_o) begin
        dv_cnt++;
        if (pend) begin
          checks++;
          if (dmem_addr_o !== prev.addr || dmem_we_o !== prev.we || dmem_wdata_o !== prev.wdata) begin
            errors++;
            $display("FAIL stall_stable: got %h/%h/%h held %h/%h/%h", dmem_addr_o, dmem_we_o,
                     dmem_wdata_o, prev.addr, prev.we, prev.wdata);
          end
        end
        prev.addr = dmem_addr_o; prev.we = dmem_we_o; prev.wdata = dmem_wdata_o;
        if (wcnt < stall_n) begin
          dmem_ready_i = 1'b0; wcnt++; pend = 1;
        end else begin
          dmem_ready_i = 1'b1; wcnt = 0; pend = 0;
          checks++;
          if (beat_q.size() == 0) begin
            errors++; $display("FAIL beat_extra: unexpected beat addr %h", dmem_addr_o);
          end else begin
            eb = beat_q.pop_front();
            if (dmem_addr_o !== eb.addr || dmem_we_o !== eb.we || (we && dmem_wdata_o !== eb.wdata)) begin
              errors++;
              $display("FAIL beat: got addr %h we %b wdata %h, want addr %h we %b wdata %h",
                       dmem_addr_o, dmem_we_o, dmem_wdata_o, eb.addr, eb.we, eb.wdata);
            end
          end
          if (we) begin
            for (int b = 0; b < 4; b++)
              if (dmem_we_o[b]) mem[dmem_addr_o[13:2]][8*b +: 8] = dmem_wdata_o[8*b +: 8];
          end else begin
            dmem_rdata_i = mem[dmem_addr_o[13:2]];
          end
        end
      end else begin
        if (pend) begin
          checks++; errors++; $display("FAIL valid_drop: dmem_valid_o fell before handshake");
        end
        pend = 0; dmem_ready_i = 1'b1;
      end
      if (resp_valid_o) begin
        got = 1; t_resp = cyc;
        o = resp_q.pop_front();
        checks++;
        if (resp_err_o !== o.err || resp_rdata_o !== o.rdata || cyc != o.cyc) begin
          errors++;
          $display("FAIL resp: got err %b rdata %h cyc %0d, want err %b rdata %h cyc %0d",
                   resp_err_o, resp_rdata_o, cyc, o.err, o.rdata, o.cyc);
        end
      end
    end
    checks++;
    if (!got || beat_q.size() != 0) begin
      errors++;
      $display("FAIL txn_done: resp seen %0d, beats left %0d, want 1 and 0", got, beat_q.size());
    end
    resp_q.delete(); beat_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_type_i = 2'b00; req_sign_ext_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; dmem_ready_i = 1'b1; dmem_rdata_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_err_o !== 1'b0 || resp_rdata_o !== 32'h0 ||
        dmem_valid_o !== 1'b0 || dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0 || dmem_we_o !== 4'h0) begin
      errors++;
      $display("FAIL reset: ready %b rv %b err %b rd %h dv %b addr %h wd %h we %b, want 1 0 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, dmem_valid_o, dmem_addr_o,
               dmem_wdata_o, dmem_we_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int ta, tr;
    txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 0, ta, tr);
    checks++;
    if (mem[32'h40] !== 32'hDEADBEEF || tr - ta != 2) begin
      errors++; $display("FAIL store_aligned: mem %h lat %0d, want deadbeef 2", mem[32'h40], tr - ta);
    end
    mem[32'h40] = 32'h0; mem[32'h41] = 32'h0;
    txn(1'b1, 2'b10, 1'b0, 32'h102, 32'hDEADBEEF, 1'b0, 32'h0, 0, ta, tr);
    checks++;
    if (mem[32'h40] !== 32'hBEEF0000 || mem[32'h41] !== 32'h0000DEAD || tr - ta != 3) begin
      errors++;
      $display("FAIL store_split: mem %h %h lat %0d, want beef0000 0000dead 3", mem[32'h40], mem[32'h41], tr - ta);
    end
  endtask

  task automatic test_load_split();
    int ta, tr;
    mem[32'h40] = 32'hAABBCCDD; mem[32'h41] = 32'h11223344;
    txn(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 1'b0, 32'h223344AA, 0, ta, tr);
    mem[1] = 32'h80000000; mem[2] = 32'h000000F1;
    txn(1'b0, 2'b01, 1'b1, 32'h007, 32'h0, 1'b0, 32'hFFFFF180, 0, ta, tr);
    txn(1'b0, 2'b01, 1'b0, 32'h007, 32'h0, 1'b0, 32'h0000F180, 0, ta, tr);
    txn(1'b0, 2'b00, 1'b1, 32'h104, 32'h0, 1'b0, 32'h00000044, 0, ta, tr);
    txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 32'hFFFFFFAA, 0, ta, tr);
  endtask

  task automatic test_errors();
    int ta, tr;
    txn(1'b0, 2'b10, 1'b0, 32'h3FFE, 32'h0, 1'b1, 32'h0, 0, ta, tr);
    checks++;
    if (dv_cnt != 0) begin errors++; $display("FAIL err_oob_bus: dmem_valid cycles %0d, want 0", dv_cnt); end
    txn(1'b1, 2'b00, 1'b0, 32'h4000, 32'h55, 1'b1, 32'h0, 0, ta, tr);
    txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 0, ta, tr);
    checks++;
    if (dv_cnt != 0) begin errors++; $display("FAIL err_type_bus: dmem_valid cycles %0d, want 0", dv_cnt); end
    txn(1'b1, 2'b00, 1'b0, 32'h3FFF, 32'hA5, 1'b0, 32'h0, 0, ta, tr);
    txn(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 1'b0, ref_load(32'h3FFC, 2'b10, 1'b0), 0, ta, tr);
    checks++;
    if (mem[12'hFFF][31:24] !== 8'hA5) begin
      errors++; $display("FAIL edge_store: byte %h, want a5", mem[12'hFFF][31:24]);
    end
    txn(1'b0, 2'b01, 1'b0, 32'h0003, 32'h0, 1'b0, ref_load(32'h3, 2'b01, 1'b0), 0, ta, tr);
    checks++;
    if (ns_rv_cyc != ta + 1 || ns_rv_err !== 1'b1 || ns_dv_cnt != 0) begin
      errors++;
      $display("FAIL nosplit_err: resp cyc %0d err %b bus %0d, want %0d 1 0", ns_rv_cyc, ns_rv_err, ns_dv_cnt, ta + 1);
    end
  endtask

  task automatic test_stall();
    int ta, tr;
    mem[32'h40] = 32'hAABBCCDD; mem[32'h41] = 32'h11223344;
    txn(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 1'b0, 32'h223344AA, 3, ta, tr);
    checks++;
    if (tr - ta != 9) begin errors++; $display("FAIL stall_latency: got %0d, want 9", tr - ta); end
    txn(1'b1, 2'b01, 1'b0, 32'h203, 32'h1234, 1'b0, 32'h0, 2, ta, tr);
    txn(1'b0, 2'b01, 1'b1, 32'h203, 32'h0, 1'b0, 32'h00001234, 1, ta, tr);
  endtask

  task automatic test_back_to_back();
    int ta0, tr0, ta1, tr1;
    txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, ref_load(32'h100, 2'b10, 1'b0), 0, ta0, tr0);
    txn(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b0, ref_load(32'h104, 2'b10, 1'b0), 0, ta1, tr1);
    checks++;
    if (ta1 - ta0 != 3) begin errors++; $display("FAIL b2b_gap: accept gap %0d, want 3", ta1 - ta0); end
  endtask

  task automatic test_reset_mid();
    int ta, tr;
    for (int k = 0; k < 20 && !req_ready_o; k++) @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_type_i = 2'b10; req_sign_ext_i = 1'b0;
    req_addr_i = 32'h103; dmem_ready_i = 1'b1;
    @(posedge clk); #1; req_valid_i = 1'b0;
    @(negedge clk);
    dmem_rdata_i = mem[32'h40];
    @(negedge clk);
    checks++;
    if (dmem_valid_o !== 1'b1 || dmem_addr_o !== 32'h104) begin
      errors++; $display("FAIL mid_beat1: dv %b addr %h, want 1 00000104", dmem_valid_o, dmem_addr_o);
    end
    dmem_ready_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || dmem_valid_o !== 1'b0 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready %b dv %b rv %b, want 1 0 0", req_ready_o, dmem_valid_o, resp_valid_o);
    end
    rst = 1'b0; dmem_ready_i = 1'b1;
    dv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid_o || dmem_valid_o) dv_cnt++;
    end
    checks++;
    if (dv_cnt != 0) begin errors++; $display("FAIL mid_quiet: active cycles %0d, want 0", dv_cnt); end
    txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, ref_load(32'h100, 2'b10, 1'b0), 0, ta, tr);
  endtask

  task automatic test_random();
    int          ta, tr;
    logic        we, sx;
    logic [1:0]  ty;
    logic [31:0] a, wd;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); sx = 1'($urandom); ty = 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 32'h3FF) + 32'h800; wd = $urandom;
      txn(we, ty, sx, a, wd, 1'b0, we ? 32'h0 : ref_load(a, ty, sx), $urandom_range(0, 2), ta, tr);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A3C_0F96;
    test_reset();
    test_store();
    test_load_split();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
